// File: rtl/serial_in.sv
// UART 8N1 receiver with a small receive FIFO and sticky error flags.
// Feeds received bytes to the CPU read path through a valid/ready pop.
module serial_in #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          uart_rx,
    output logic [7:0]                    char,
    output logic                          char_valid,
    input  logic                          char_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          framing_err,
    output logic                          overrun_err,
    input  logic                          err_clear
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          rx_meta;
    logic          rx_s;
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [2:0]    idx_q;
    logic [2:0]    idx_d;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic          stop_ok;
    logic          stop_bad;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rd_d;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic [7:0]    head_q;
    logic [7:0]    head_d;
    logic          pop;
    logic          push;
    logic          drop;
    logic          fe_q;
    logic          oe_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    stop_ok  = rx_s;
                    stop_bad = !rx_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign pop  = (level_q != '0) && char_ready;
    assign push = stop_ok && ((level_q != FULL) || pop);
    assign drop = stop_ok && (level_q == FULL) && !pop;

    always_comb begin
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        level_d = level_q;
        if (push && !pop) level_d = level_q + LW'(1);
        if (pop && !push) level_d = level_q - LW'(1);
        if (level_d == '0) begin
            head_d = '0;
        end else if (push && (rd_d == wr_q)) begin
            head_d = shift_q;
        end else begin
            head_d = mem[rd_d];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            head_q  <= '0;
        end else begin
            if (push) begin
                mem[wr_q] <= shift_q;
                wr_q      <= wr_q + AW'(1);
            end
            rd_q    <= rd_d;
            level_q <= level_d;
            head_q  <= head_d;
        end
    end

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fe_q <= 1'b0;
            oe_q <= 1'b0;
        end else begin
            if (stop_bad) fe_q <= 1'b1;
            else if (err_clear) fe_q <= 1'b0;
            if (drop) oe_q <= 1'b1;
            else if (err_clear) oe_q <= 1'b0;
        end
    end

    assign char        = head_q;
    assign char_valid  = (level_q != '0);
    assign fifo_level  = level_q;
    assign framing_err = fe_q;
    assign overrun_err = oe_q;

endmodule

// File: tb/tb_serial_in.sv
// Bench for serial_in: frame-level reference model plus directed and
// randomized UART traffic at 8 clocks per bit.
module tb_serial_in;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    // Stop decision edge relative to the edge after which the start bit is driven.
    localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] char;
    logic       char_valid;
    logic       char_ready = 1'b0;
    logic [2:0] fifo_level;
    logic       framing_err;
    logic       overrun_err;
    logic       err_clear = 1'b0;

    serial_in #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .uart_rx    (uart_rx),
        .char       (char),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .fifo_level (fifo_level),
        .framing_err(framing_err),
        .overrun_err(overrun_err),
        .err_clear  (err_clear)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int unsigned at_cyc;
        logic [7:0]  b;
        logic        ok;
    } ev_t;

    int unsigned cyc = 0;
    logic [7:0]  q[$];
    ev_t         evq[$];
    ev_t         ev;
    bit          m_fe = 0;
    bit          m_oe = 0;
    bit          m_pop;

    // Reference: each frame resolves at a known edge; the FIFO is a queue.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q.delete();
            evq.delete();
            m_fe = 0;
            m_oe = 0;
        end else begin
            cyc++;
            m_pop = char_ready && (q.size() > 0);
            if (err_clear) begin
                m_fe = 0;
                m_oe = 0;
            end
            if (m_pop) void'(q.pop_front());
            if (evq.size() > 0 && evq[0].at_cyc == cyc) begin
                ev = evq.pop_front();
                if (!ev.ok) m_fe = 1;
                else if (q.size() < DEPTH) q.push_back(ev.b);
                else m_oe = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_char", {24'd0, char}, (q.size() > 0) ? {24'd0, q[0]} : 32'd0);
        chk("m_valid", {31'd0, char_valid}, {31'd0, q.size() > 0});
        chk("m_level", {29'd0, fifo_level}, q.size());
        chk("m_fe", {31'd0, framing_err}, {31'd0, m_fe});
        chk("m_oe", {31'd0, overrun_err}, {31'd0, m_oe});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after an edge; returns just after the edge ending the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        ev_t e;
        e.at_cyc = cyc + STOP_EDGE;
        e.b = b;
        e.ok = stop;
        evq.push_back(e);
        uart_rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            step(CPB);
        end
        uart_rx = stop;
        step(CPB);
        uart_rx = 1'b1;
    endtask

    task automatic drain();
        char_ready = 1'b1;
        step(DEPTH + 1);
        char_ready = 1'b0;
        step(1);
    endtask

    bit done = 0;
    int unsigned e0;
    logic [7:0] c3 = 8'hC3;

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        step(3);
        @(negedge clk);
        chk("rst_char", {24'd0, char}, 32'd0);
        chk("rst_valid", {31'd0, char_valid}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        nrst = 1'b1;
        step(4);

        e0 = cyc;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                step(STOP_EDGE - 1);
                @(negedge clk);
                chk("single_early_valid", {31'd0, char_valid}, 32'd0);
                step(1);
                @(negedge clk);
                chk("single_valid", {31'd0, char_valid}, 32'd1);
                chk("single_char", {24'd0, char}, 32'h0000_00A5);
                chk("single_level", {29'd0, fifo_level}, 32'd1);
                chk("single_fe", {31'd0, framing_err}, 32'd0);
                chk("single_oe", {31'd0, overrun_err}, 32'd0);
            end
        join
        step(2);
        drain();

        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        step(2);
        char_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_char", {24'd0, char}, 32'(i + 1));
            step(1);
        end
        char_ready = 1'b0;
        @(negedge clk);
        chk("b2b_empty_valid", {31'd0, char_valid}, 32'd0);
        chk("b2b_empty_char", {24'd0, char}, 32'd0);
        chk("b2b_empty_level", {29'd0, fifo_level}, 32'd0);
        step(1);

        for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b1);
        step(2);
        chk("ovr_level", {29'd0, fifo_level}, 32'd4);
        chk("ovr_flag", {31'd0, overrun_err}, 32'd1);
        char_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ovr_pop_char", {24'd0, char}, 32'(8'h10 + i));
            step(1);
        end
        char_ready = 1'b0;
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        @(negedge clk);
        chk("ovr_cleared", {31'd0, overrun_err}, 32'd0);
        step(1);

        send_byte(8'h55, 1'b0);
        step(16);
        chk("frm_flag_mid", {31'd0, framing_err}, 32'd1);
        chk("frm_level_mid", {29'd0, fifo_level}, 32'd0);
        send_byte(8'h66, 1'b1);
        step(2);
        chk("frm_level", {29'd0, fifo_level}, 32'd1);
        chk("frm_char", {24'd0, char}, 32'h66);
        chk("frm_flag", {31'd0, framing_err}, 32'd1);
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        drain();

        uart_rx = 1'b0;
        step(2);
        uart_rx = 1'b1;
        step(20);
        chk("glitch_level", {29'd0, fifo_level}, 32'd0);
        chk("glitch_fe", {31'd0, framing_err}, 32'd0);
        chk("glitch_oe", {31'd0, overrun_err}, 32'd0);

        send_byte(8'h77, 1'b1);
        send_byte(8'h12, 1'b0);
        step(4);
        uart_rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 4; i++) begin
            uart_rx = c3[i];
            step(CPB);
        end
        uart_rx = c3[4];
        step(CPB / 2);
        nrst = 1'b0;
        uart_rx = 1'b1;
        @(negedge clk);
        chk("rmid_char", {24'd0, char}, 32'd0);
        chk("rmid_valid", {31'd0, char_valid}, 32'd0);
        chk("rmid_level", {29'd0, fifo_level}, 32'd0);
        chk("rmid_fe", {31'd0, framing_err}, 32'd0);
        chk("rmid_oe", {31'd0, overrun_err}, 32'd0);
        step(3);
        nrst = 1'b1;
        step(4);
        send_byte(8'h3C, 1'b1);
        step(2);
        chk("rmid_after_level", {29'd0, fifo_level}, 32'd1);
        chk("rmid_after_char", {24'd0, char}, 32'h3C);
        drain();

        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    logic bad;
                    bad = ($urandom % 8) == 0;
                    send_byte(8'($urandom), !bad);
                    if (bad) step(16);
                    else if (($urandom % 3) == 0) step($urandom_range(1, 20));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    char_ready = ($urandom % 3) == 0;
                    err_clear = ($urandom % 40) == 0;
                    step(1);
                end
                char_ready = 1'b0;
                err_clear = 1'b0;
            end
        join
        step(4);
        drain();
        step(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
